down_counter_timer: RTL and testbench

//  Loadable binary down-counter timer; the counting-down end of the up-counter

---
 rtl/cnt_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/down_counter_timer.sv | 125 ++++++++++++
 tb/tb_down_counter_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the counter family.
//   - FSM state encoding for down_counter_timer (IDLE/RUN/HOLD)
//   - CNT_WIDTH_DEF: default counter width shared with the up-counter
package cnt_pkg;

   typedef logic [1:0] cnt_state_t;

   localparam cnt_state_t ST_IDLE = 2'd0;
   localparam cnt_state_t ST_RUN  = 2'd1;
   localparam cnt_state_t ST_HOLD = 2'd2;

   localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle tick strobes, one every PRESCALE enabled cycles.
//   clock    in  : clock, all updates on posedge
//   clear    in  : synchronous active-high reset
//   en       in  : advance the phase counter this cycle
//   sync_clr in  : return the phase to zero (abort of a count)
//   tick     out : high on the enabled cycle where the phase wraps
// With PRESCALE=1 the phase register is constant zero and tick follows en.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic clear,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Phase only moves while enabled, so a pause freezes it mid-interval
   // and counting resumes from the same phase.
   always_ff @(posedge clock) begin
      if (clear || sync_clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts Q toward zero on prescaled ticks and
// pulses done for one cycle at terminal count.
//   clock    in  : clock
//   clear    in  : synchronous active-high reset, highest priority
//   load     in  : Q <= load_val (IDLE only)
//   load_val in  : start value, WIDTH bits
//   start    in  : begin counting (IDLE only)
//   pause    in  : level, freeze count and prescaler while high
//   stop     in  : abort RUN/HOLD to IDLE, Q keeps its value
//   Q        out : current count, registered
//   busy     out : high in RUN and HOLD
//   done     out : one-cycle pulse at terminal count
// Build option AUTO_RELOAD_EN: at terminal count reload the last loaded value
// and keep running (periodic done); without it the timer is one-shot.
module down_counter_timer
   import cnt_pkg::*;
#(
   parameter int WIDTH    = CNT_WIDTH_DEF,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             done
);

   cnt_state_t       state;
   logic             tick;
   logic             pre_en;
   logic             pre_clr;
   logic [WIDTH-1:0] start_val;

`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;
`endif

   // Prescaler advances only in RUN with neither stop nor pause winning
   // this cycle; stop also zeroes its phase.
   assign pre_en  = (state == ST_RUN) && !stop && !pause;
   assign pre_clr = (state != ST_IDLE) && stop;

   // A same-cycle load decides start against the new value, not the old Q.
   assign start_val = load ? load_val : Q;

   assign busy = (state == ST_RUN) || (state == ST_HOLD);

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clock    (clock),
      .clear    (clear),
      .en       (pre_en),
      .sync_clr (pre_clr),
      .tick     (tick)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= ST_IDLE;
         Q     <= '0;
         done  <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  Q <= load_val;
`ifdef AUTO_RELOAD_EN
                  reload <= load_val;
`endif
               end
               if (start) begin
                  if (start_val != '0)
                     state <= ST_RUN;
                  else
                     done <= 1'b1;   // nothing to count: report expiry at once
               end
            end
            ST_RUN: begin
               if (stop)
                  state <= ST_IDLE;
               else if (pause)
                  state <= ST_HOLD;
               else if (tick) begin
                  if (Q == WIDTH'(1)) begin
                     done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                     if (reload != '0)
                        Q <= reload;
                     else begin
                        Q     <= '0;
                        state <= ST_IDLE;
                     end
`else
                     Q     <= '0;
                     state <= ST_IDLE;
`endif
                  end else begin
                     // RUN is only entered with Q!=0 and leaves at Q==1,
                     // so this never passes below zero.
                     Q <= Q - WIDTH'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (stop)
                  state <= ST_IDLE;
               else if (!pause)
                  state <= ST_RUN;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

   localparam int W = 4;
`ifdef AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         clear = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         stop = 1'b0;

   logic [W-1:0] qa, qb;
   logic         busya, busyb, donea, doneb;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   // Instance A: PRESCALE=1, instance B: PRESCALE=3, same stimulus.
   down_counter_timer #(.WIDTH(W), .PRESCALE(1)) dut_a (
      .clock(clock), .clear(clear), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .stop(stop),
      .Q(qa), .busy(busya), .done(donea));

   down_counter_timer #(.WIDTH(W), .PRESCALE(3)) dut_b (
      .clock(clock), .clear(clear), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .stop(stop),
      .Q(qb), .busy(busyb), .done(doneb));

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_HOLD} mmode_t;
   mmode_t mmode [2];
   int     mq    [2];
   int     mphase[2];   // cycles counted in the current tick interval
   int     mrel  [2];
   bit     mdone [2];
   bit     mvalid = 1'b0;
   int     ps    [2] = '{1, 3};

   always @(posedge clock) begin
      if (clear) mvalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            mmode[i] = M_IDLE; mq[i] = 0; mphase[i] = 0; mrel[i] = 0; mdone[i] = 0;
         end else begin
            mdone[i] = 0;
            if (mmode[i] == M_IDLE) begin
               int sv;
               sv = load ? int'(load_val) : mq[i];
               if (load) begin mq[i] = int'(load_val); mrel[i] = int'(load_val); end
               if (start) begin
                  if (sv != 0) mmode[i] = M_RUN;
                  else mdone[i] = 1;
               end
            end else if (stop) begin
               mmode[i] = M_IDLE; mphase[i] = 0;
            end else if (mmode[i] == M_HOLD) begin
               if (!pause) mmode[i] = M_RUN;
            end else if (pause) begin
               mmode[i] = M_HOLD;
            end else begin
               mphase[i] = mphase[i] + 1;
               if (mphase[i] == ps[i]) begin
                  mphase[i] = 0;
                  if (mq[i] == 1) begin
                     mdone[i] = 1;
                     if (AUTO && mrel[i] != 0) mq[i] = mrel[i];
                     else begin mq[i] = 0; mmode[i] = M_IDLE; end
                  end else begin
                     mq[i] = mq[i] - 1;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once the model has seen a reset.
   always @(posedge clock) begin
      #1;
      if (mvalid) begin
         chk("A.Q",    32'(qa),    32'(mq[0]));
         chk("A.busy", 32'(busya), 32'(mmode[0] != M_IDLE));
         chk("A.done", 32'(donea), 32'(mdone[0]));
         chk("B.Q",    32'(qb),    32'(mq[1]));
         chk("B.busy", 32'(busyb), 32'(mmode[1] != M_IDLE));
         chk("B.done", 32'(doneb), 32'(mdone[1]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clock); #2;
   endtask

   task automatic idle_in();
      clear = 0; load = 0; start = 0; pause = 0; stop = 0;
   endtask

   task automatic do_clear();
      idle_in(); clear = 1; cyc(); clear = 0;
   endtask

   task automatic load_start(input int v);
      load_val = W'(v); load = 1; start = 1; cyc(); load = 0; start = 0;
   endtask

   task automatic expect_a(input string n, input int q, input int b, input int d);
      chk({n, ".q"}, 32'(qa), 32'(q));
      chk({n, ".busy"}, 32'(busya), 32'(b));
      chk({n, ".done"}, 32'(donea), 32'(d));
   endtask

   initial begin
      // 1: clear dominates load+start
      clear = 1; load = 1; start = 1; load_val = 4'd5;
      cyc(); expect_a("t1a", 0, 0, 0);
      cyc(); expect_a("t1b", 0, 0, 0);
      idle_in();

      // 2: load+start together, count 5..0
      load_start(5); expect_a("t2_5", 5, 1, 0);
      for (int v = 4; v >= 1; v--) begin cyc(); expect_a("t2_run", v, 1, 0); end
      cyc(); expect_a("t2_term", 0, 0, 1);
      cyc(); expect_a("t2_after", 0, 0, 0);

      // 3: PRESCALE=3 on instance B
      do_clear();
      load_start(2); chk("t3_load", 32'(qb), 32'd2);
      cyc(); cyc(); chk("t3_hold", 32'(qb), 32'd2);
      cyc(); chk("t3_q1", 32'(qb), 32'd1);
      cyc(); cyc(); chk("t3_q1b", 32'(qb), 32'd1); chk("t3_nodone", 32'(doneb), 32'd0);
      cyc(); chk("t3_q0", 32'(qb), 32'd0); chk("t3_done", 32'(doneb), 32'd1);
      chk("t3_busy", 32'(busyb), 32'd0);
      cyc(); chk("t3_done_once", 32'(doneb), 32'd0);

      // 4: pause at 6, then load while busy ignored
      do_clear();
      load_start(9);
      cyc(); cyc(); cyc(); expect_a("t4_at6", 6, 1, 0);
      pause = 1;
      repeat (4) begin cyc(); expect_a("t4_held", 6, 1, 0); end
      pause = 0;
      cyc(); expect_a("t4_unhold", 6, 1, 0);
      cyc(); expect_a("t4_resume", 5, 1, 0);
      load_val = 4'd3; load = 1;
      cyc(); expect_a("t4_ignload", 4, 1, 0);
      load = 0;
      cyc(); cyc(); cyc(); expect_a("t4_q1", 1, 1, 0);
`ifndef AUTO_RELOAD_EN
      cyc(); expect_a("t4_term", 0, 0, 1);
`endif

      // 5: stop at 4, restart, then start with Q==0
      do_clear();
      load_start(7);
      cyc(); cyc(); cyc(); expect_a("t5_at4", 4, 1, 0);
      stop = 1; cyc(); stop = 0; expect_a("t5_stop", 4, 0, 0);
      cyc(); expect_a("t5_idle", 4, 0, 0);
      start = 1; cyc(); start = 0; expect_a("t5_restart", 4, 1, 0);
      cyc(); expect_a("t5_q3", 3, 1, 0);
      cyc(); cyc(); expect_a("t5_q1", 1, 1, 0);
`ifndef AUTO_RELOAD_EN
      cyc(); expect_a("t5_term", 0, 0, 1);
      start = 1; cyc(); start = 0; expect_a("t5_zero_start", 0, 0, 1);
      cyc(); expect_a("t5_zero_after", 0, 0, 0);
`endif

      // 6: periodic reload (when built in), clear mid-run
      do_clear();
      load_start(3); expect_a("t6_load", 3, 1, 0);
      cyc(); cyc(); expect_a("t6_q1", 1, 1, 0);
`ifdef AUTO_RELOAD_EN
      cyc(); expect_a("t6_reload", 3, 1, 1);
      cyc(); cyc(); expect_a("t6_q1b", 1, 1, 0);
      cyc(); expect_a("t6_reload2", 3, 1, 1);
`endif
      clear = 1; cyc(); clear = 0; expect_a("t6_clear", 0, 0, 0);

      // stop while paused
      load_start(5); pause = 1; cyc(); expect_a("hold_a", 5, 1, 0);
      stop = 1; cyc(); stop = 0; pause = 0; expect_a("hold_stop", 5, 0, 0);

      // randomized tail, checked by the model on every cycle
      for (int n = 0; n < 400; n++) begin
         clear    = ($urandom_range(0, 60) == 0);
         load     = ($urandom_range(0, 3) == 0);
         load_val = W'($urandom_range(0, 15));
         start    = ($urandom_range(0, 2) == 0);
         pause    = ($urandom_range(0, 4) == 0);
         stop     = ($urandom_range(0, 15) == 0);
         cyc();
      end
      idle_in();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
